switch_event_classifier: RTL
============================

SWITCH_EVENT_CLASSIFIER -- requirements
Module: switch_event_classifier

Interface
REQ-001 Parameter LONG_CNT, default 100_000_000; cycles a press must last to count as long (1 s at 100 MHz).
REQ-002 Parameter DCLICK_CNT, default 30_000_000; cycles after a release in which a second press forms a double click (300 ms).
REQ-003 iClk  in  1  single system clock; all logic on its rising edge.
REQ-004 iRst  in  1  reset, asynchronous, active-high.
REQ-005 iSwDown  in  1  single-cycle debounced press pulse from the switch detector.
REQ-006 iSwUp  in  1  single-cycle debounced release pulse from the switch detector.
REQ-007 oEvtValid  out  1  event available.
REQ-008 oEvtCode  out  3  event code: 1 SHORT, 2 DOUBLE, 3 LONG, 4 LONG_RELEASE; 0 when no event is pending.
REQ-009 iEvtReady  in  1  consumer accepts the event when high together with oEvtValid.
REQ-010 oHeld  out  1  high while a long press is still held.
REQ-011 oOvf  out  1  sticky flag: an event was dropped.
REQ-012 iClrOvf  in  1  clears oOvf.

Function
REQ-013 State machine states: IDLE, PRESS1, WAIT2, PRESS2, HOLD. A 27-bit counter cnt clears to 0 on every state entry and increments once per cycle in PRESS1, WAIT2 and PRESS2.
REQ-014 Input pulses:
- iSwDown and iSwUp high in the same cycle: the block ignores both in every state.
- iSwDown in PRESS1, PRESS2 or HOLD: ignored.
- iSwUp in IDLE or WAIT2: ignored.
REQ-015 IDLE: iSwDown -> PRESS1.
REQ-016 PRESS1 transitions:
- iSwUp while cnt < LONG_CNT-1 -> WAIT2.
- cnt == LONG_CNT-1 with no iSwUp -> emit LONG, go to HOLD.
REQ-017 WAIT2 transitions:
- iSwDown while cnt < DCLICK_CNT-1 -> PRESS2.
- cnt == DCLICK_CNT-1 with no iSwDown -> emit SHORT, go to IDLE.
REQ-018 PRESS2 transitions:
- iSwUp before the timeout -> emit DOUBLE, go to IDLE.
- cnt == LONG_CNT-1 -> emit LONG, go to HOLD; no DOUBLE is emitted.
REQ-019 HOLD: oHeld = 1; iSwUp -> emit LONG_RELEASE, go to IDLE, oHeld = 0 in the following cycle.
REQ-020 Timeout when the input pulse arrives in the same cycle: the input pulse takes priority over the timeout.
REQ-021 Emission timing: an emission decided at clock edge T appears on oEvtValid/oEvtCode after edge T+1.
REQ-022 Output register, one deep:
- Loads the emitted event when oEvtValid = 0, or when oEvtValid = 1 and iEvtReady = 1 in the same cycle (back-to-back transfer).
- Otherwise the new event is dropped and oOvf is set to 1; the held event is unchanged.
REQ-023 Accept without a new emission: oEvtValid = 1 and iEvtReady = 1 -> oEvtValid = 0 and oEvtCode = 0 the next cycle.
REQ-024 oEvtCode stays stable while oEvtValid = 1 and iEvtReady = 0.
REQ-025 oOvf: iClrOvf clears it; if a drop occurs in the same cycle, the set wins.
REQ-026 Parameter legality: 2 <= LONG_CNT, DCLICK_CNT <= 2^27-1; the counter never wraps.

Reset
REQ-027 While iRst = 1:
- State = IDLE, cnt = 0.
- oEvtValid = 0, oEvtCode = 0, oHeld = 0, oOvf = 0.
REQ-028 Reset mid-press: the in-progress sequence is discarded; a later iSwUp produces no event.

Structure
REQ-029 Shared package switch_evt_pkg holds:
- Event code constants (EVT_NONE, EVT_SHORT, EVT_DOUBLE, EVT_LONG, EVT_LONG_REL).
- State encoding.
- Default LONG_CNT and DCLICK_CNT.
- Counter width 27.
REQ-030 Single module, no sub-module; counter and output register are inline.

Verification (LONG_CNT=20, DCLICK_CNT=10, iEvtReady=1 unless stated)
REQ-031 SHORT: iSwDown at T, iSwUp at T+5 -> oEvtValid with code 1 at cycle T+16 (11 cycles after iSwUp), one cycle long.
REQ-032 DOUBLE: iSwDown T, iSwUp T+5, iSwDown T+9, iSwUp T+12 -> code 2 at T+13; no code 1 at any time.
REQ-033 LONG: iSwDown at T, held -> code 3 at T+21 and oHeld = 1 from T+21; iSwUp at T+30 -> code 4 at T+31 and oHeld = 0 at T+31.
REQ-034 Overflow: iEvtReady=0, two SHORT sequences -> code 1 held throughout, second event dropped, oOvf = 1; iClrOvf pulse -> oOvf = 0; iEvtReady = 1 -> oEvtValid falls next cycle.
REQ-035 Corner cases:
- iSwDown and iSwUp together in IDLE -> no event.
- iRst asserted at T+3 of a press -> all outputs 0 immediately; iSwUp at T+5 -> no event.
- iSwUp coinciding with cnt = LONG_CNT-1 -> WAIT2 and no code 3.

Source files
------------

// File: rtl/switch_evt_pkg.sv
// Shared constants for the switch event classifier:
// event codes, FSM state encoding, counter width and default timings.
package switch_evt_pkg;

  localparam int CNT_W = 27;

  localparam int LONG_CNT_DEF   = 100_000_000;
  localparam int DCLICK_CNT_DEF = 30_000_000;

  typedef logic [2:0] evt_code_t;

  localparam evt_code_t EVT_NONE     = 3'd0;
  localparam evt_code_t EVT_SHORT    = 3'd1;
  localparam evt_code_t EVT_DOUBLE   = 3'd2;
  localparam evt_code_t EVT_LONG     = 3'd3;
  localparam evt_code_t EVT_LONG_REL = 3'd4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_WAIT2  = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

endpackage

// File: rtl/switch_event_classifier.sv
// Classifies debounced press/release pulses into SHORT, DOUBLE,
// LONG and LONG_RELEASE events behind a one-deep output register.
module switch_event_classifier
  import switch_evt_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEF,
  parameter int DCLICK_CNT = DCLICK_CNT_DEF
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSwDown,
  input  logic       iSwUp,
  output logic       oEvtValid,
  output logic [2:0] oEvtCode,
  input  logic       iEvtReady,
  output logic       oHeld,
  output logic       oOvf,
  input  logic       iClrOvf
);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST =
    CNT_W'(DCLICK_CNT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_dn;
  logic             w_up;
  logic             w_long_to;
  logic             w_dclk_to;
  logic             w_counting;

  logic             w_emit_v;
  evt_code_t        w_emit_code;
  logic             r_emit_v;
  evt_code_t        r_emit_code;

  logic             r_evt_v;
  evt_code_t        r_evt_code;
  logic             r_held;
  logic             r_ovf;

  logic             w_load;
  logic             w_drop;

  // Simultaneous press and release cancel each other out.
  assign w_dn = iSwDown & ~iSwUp;
  assign w_up = iSwUp & ~iSwDown;

  assign w_long_to = (r_cnt == LONG_LAST);
  assign w_dclk_to = (r_cnt == DCLK_LAST);

  assign w_counting = (r_state == ST_PRESS1) |
                      (r_state == ST_WAIT2)  |
                      (r_state == ST_PRESS2);

  // Next-state and emission decode; input pulses win over timeouts.
  always_comb begin
    w_state_nxt = r_state;
    w_emit_v    = 1'b0;
    w_emit_code = EVT_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_dn) w_state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_up) begin
          w_state_nxt = ST_WAIT2;
        end else if (w_long_to) begin
          w_state_nxt = ST_HOLD;
          w_emit_v    = 1'b1;
          w_emit_code = EVT_LONG;
        end
      end
      ST_WAIT2: begin
        if (w_dn) begin
          w_state_nxt = ST_PRESS2;
        end else if (w_dclk_to) begin
          w_state_nxt = ST_IDLE;
          w_emit_v    = 1'b1;
          w_emit_code = EVT_SHORT;
        end
      end
      ST_PRESS2: begin
        if (w_up) begin
          w_state_nxt = ST_IDLE;
          w_emit_v    = 1'b1;
          w_emit_code = EVT_DOUBLE;
        end else if (w_long_to) begin
          w_state_nxt = ST_HOLD;
          w_emit_v    = 1'b1;
          w_emit_code = EVT_LONG;
        end
      end
      ST_HOLD: begin
        if (w_up) begin
          w_state_nxt = ST_IDLE;
          w_emit_v    = 1'b1;
          w_emit_code = EVT_LONG_REL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Cycle counter: cleared on every state entry, runs in timed states.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_counting) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Emission staging register; gives the one-cycle emit latency.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_emit_v    <= 1'b0;
      r_emit_code <= EVT_NONE;
    end else begin
      r_emit_v    <= w_emit_v;
      r_emit_code <= w_emit_code;
    end
  end

  assign w_load = r_emit_v & (~r_evt_v | iEvtReady);
  assign w_drop = r_emit_v & r_evt_v & ~iEvtReady;

  // One-deep output register with back-to-back transfer.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_evt_v    <= 1'b0;
      r_evt_code <= EVT_NONE;
    end else if (w_load) begin
      r_evt_v    <= 1'b1;
      r_evt_code <= r_emit_code;
    end else if (r_evt_v & iEvtReady) begin
      r_evt_v    <= 1'b0;
      r_evt_code <= EVT_NONE;
    end
  end

  // Sticky overflow; a drop in the clear cycle keeps it set.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (iClrOvf) r_ovf <= 1'b0;
  end

  // Held flag trails the HOLD state by one cycle, aligned with events.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_held <= 1'b0;
    else      r_held <= (r_state == ST_HOLD);
  end

  assign oEvtValid = r_evt_v;
  assign oEvtCode  = r_evt_code;
  assign oHeld     = r_held;
  assign oOvf      = r_ovf;

endmodule
